// File: rtl/cv32e40p_apu_responder.sv
// APU responder model: accepts operations over req/gnt and returns a fixed
// integer result plus flags on rvalid after a fixed LATENCY-stage pipeline.
module cv32e40p_apu_responder #(
   parameter int unsigned LATENCY         = 2,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic             clk_i,
   input  logic             rst_n,
   input  logic             apu_req_i,
   output logic             apu_gnt_o,
   input  logic [2:0][31:0] apu_operands_i,
   input  logic [5:0]       apu_op_i,
   input  logic [14:0]      apu_flags_i,
   input  logic             gnt_stall_i,
   output logic             apu_rvalid_o,
   output logic [31:0]      apu_result_o,
   output logic [4:0]       apu_rflags_o
);

   localparam int unsigned   CW      = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

   typedef enum logic [5:0] {
      OP_ADD = 6'd0,
      OP_SUB = 6'd1,
      OP_MUL = 6'd2,
      OP_MAC = 6'd3,
      OP_MIN = 6'd4,
      OP_MAX = 6'd5
   } op_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] result;
      logic [4:0]  rflags;
   } stage_t;

   logic [CW-1:0] r_outstanding;
   stage_t        r_pipe [LATENCY];
   stage_t        w_new;
   logic          w_accept;
   logic [31:0]   w_a, w_b, w_c;
   logic [31:0]   w_sum, w_diff, w_prod;
   logic [31:0]   w_res;
   logic [4:0]    w_fl;
   logic          w_unused;

   assign w_unused = ^apu_flags_i;

   assign apu_gnt_o = rst_n && apu_req_i && !gnt_stall_i && (r_outstanding < MAX_CNT);
   assign w_accept  = apu_req_i && apu_gnt_o;

   assign w_a    = apu_operands_i[0];
   assign w_b    = apu_operands_i[1];
   assign w_c    = apu_operands_i[2];
   assign w_sum  = w_a + w_b;
   assign w_diff = w_a - w_b;
   assign w_prod = w_a * w_b;

   // Flags are {NV,DZ,OF,UF,NX}; only OF (ADD/SUB) and NV (unsupported op) are used.
   always_comb begin
      w_res = '0;
      w_fl  = '0;
      case (apu_op_i)
         OP_ADD: begin
            w_res   = w_sum;
            w_fl[2] = (w_a[31] == w_b[31]) && (w_sum[31] != w_a[31]);
         end
         OP_SUB: begin
            w_res   = w_diff;
            w_fl[2] = (w_a[31] != w_b[31]) && (w_diff[31] != w_a[31]);
         end
         OP_MUL:  w_res = w_prod;
         OP_MAC:  w_res = w_prod + w_c;
         OP_MIN:  w_res = ($signed(w_a) < $signed(w_b)) ? w_a : w_b;
         OP_MAX:  w_res = ($signed(w_a) > $signed(w_b)) ? w_a : w_b;
         default: w_fl[4] = 1'b1;
      endcase
      w_new = w_accept ? {1'b1, w_res, w_fl} : '0;
   end

   // Idle stages carry zeros so the outputs read 0 whenever rvalid is low.
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= w_new;
         for (int unsigned i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign apu_rvalid_o = r_pipe[LATENCY-1].valid;
   assign apu_result_o = r_pipe[LATENCY-1].result;
   assign apu_rflags_o = r_pipe[LATENCY-1].rflags;

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         r_outstanding <= '0;
      end else begin
         case ({w_accept, apu_rvalid_o})
            2'b10:   r_outstanding <= r_outstanding + 1'b1;
            2'b01:   r_outstanding <= r_outstanding - 1'b1;
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_n) begin
         assert (r_outstanding <= MAX_CNT);
         assert (!(apu_rvalid_o && !w_accept && r_outstanding == '0));
      end
   end

endmodule

// File: tb/tb_cv32e40p_apu_responder.sv
// Directed bench for cv32e40p_apu_responder: opcode vector table on a
// LATENCY=2 instance, occupancy and reset-drop sequences on a LATENCY=4 one.
module tb_cv32e40p_apu_responder;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [14:0]      flags_in = 15'h0;

   logic             a_req, a_stall, a_gnt, a_rv;
   logic [2:0][31:0] a_ops;
   logic [5:0]       a_op;
   logic [31:0]      a_res;
   logic [4:0]       a_fl;

   logic             b_req, b_stall, b_gnt, b_rv;
   logic [2:0][31:0] b_ops;
   logic [5:0]       b_op;
   logic [31:0]      b_res;
   logic [4:0]       b_fl;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cv32e40p_apu_responder #(.LATENCY(2), .MAX_OUTSTANDING(2)) u_dut (
      .clk_i(clk), .rst_n(rst_n), .apu_req_i(a_req), .apu_gnt_o(a_gnt),
      .apu_operands_i(a_ops), .apu_op_i(a_op), .apu_flags_i(flags_in),
      .gnt_stall_i(a_stall), .apu_rvalid_o(a_rv), .apu_result_o(a_res),
      .apu_rflags_o(a_fl)
   );

   cv32e40p_apu_responder #(.LATENCY(4), .MAX_OUTSTANDING(2)) u_occ (
      .clk_i(clk), .rst_n(rst_n), .apu_req_i(b_req), .apu_gnt_o(b_gnt),
      .apu_operands_i(b_ops), .apu_op_i(b_op), .apu_flags_i(flags_in),
      .gnt_stall_i(b_stall), .apu_rvalid_o(b_rv), .apu_result_o(b_res),
      .apu_rflags_o(b_fl)
   );

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic [31:0] a, b, c;
      logic [31:0] exp_res;
      logic [4:0]  exp_fl;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v);
      tick();
      a_req = 1'b1; a_op = v.op; a_ops[0] = v.a; a_ops[1] = v.b; a_ops[2] = v.c;
      #1 chk({v.name, " gnt"}, 32'(a_gnt), 32'd1);
      tick();
      a_req = 1'b0; a_ops = '1; a_op = 6'd0;
      #1 chk({v.name, " early"}, 32'(a_rv), 32'd0);
      tick();
      #1 chk({v.name, " rvalid"}, 32'(a_rv), 32'd1);
      chk({v.name, " result"}, a_res, v.exp_res);
      chk({v.name, " rflags"}, 32'(a_fl), 32'(v.exp_fl));
      tick();
      #1 chk({v.name, " pulse"}, 32'(a_rv), 32'd0);
      chk({v.name, " res0"}, a_res, 32'd0);
   endtask

   initial begin
      vecs[0]  = '{"add",      6'd0,  32'd5,        32'd7,        32'd0,  32'h0000000C, 5'b00000};
      vecs[1]  = '{"add_of",   6'd0,  32'h7FFFFFFF, 32'd1,        32'd0,  32'h80000000, 5'b00100};
      vecs[2]  = '{"add_wrap", 6'd0,  32'hFFFFFFFF, 32'd1,        32'd0,  32'h00000000, 5'b00000};
      vecs[3]  = '{"sub_of",   6'd1,  32'h80000000, 32'd1,        32'd0,  32'h7FFFFFFF, 5'b00100};
      vecs[4]  = '{"sub_neg",  6'd1,  32'd5,        32'd7,        32'd0,  32'hFFFFFFFE, 5'b00000};
      vecs[5]  = '{"sub_of2",  6'd1,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0,  32'h80000000, 5'b00100};
      vecs[6]  = '{"mul",      6'd2,  32'h00012345, 32'h10,       32'd0,  32'h00123450, 5'b00000};
      vecs[7]  = '{"mul_wrap", 6'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,  32'h00000001, 5'b00000};
      vecs[8]  = '{"mac",      6'd3,  32'd3,        32'd4,        32'd10, 32'd22,       5'b00000};
      vecs[9]  = '{"min",      6'd4,  32'hFFFFFFFF, 32'd1,        32'd0,  32'hFFFFFFFF, 5'b00000};
      vecs[10] = '{"max",      6'd5,  32'hFFFFFFFF, 32'd1,        32'd0,  32'h00000001, 5'b00000};
      vecs[11] = '{"max_ext",  6'd5,  32'h80000000, 32'h7FFFFFFF, 32'd0,  32'h7FFFFFFF, 5'b00000};
      vecs[12] = '{"op6",      6'd6,  32'd9,        32'd9,        32'd9,  32'h00000000, 5'b10000};
      vecs[13] = '{"op63",     6'd63, 32'd1,        32'd2,        32'd3,  32'h00000000, 5'b10000};

      rst_n = 1'b0;
      a_req = 1'b1; a_stall = 1'b0; a_op = 6'd0; a_ops = '0;
      b_req = 1'b1; b_stall = 1'b0; b_op = 6'd0; b_ops = '0;
      tick(); tick();
      #1 chk("rst gnt_a", 32'(a_gnt), 32'd0);
      chk("rst gnt_b", 32'(b_gnt), 32'd0);
      tick();
      rst_n = 1'b1; a_req = 1'b0; b_req = 1'b0;
      #1 chk("rst rv_a", 32'(a_rv), 32'd0);
      chk("rst res_a", a_res, 32'd0);
      chk("rst fl_a", 32'(a_fl), 32'd0);
      chk("rst rv_b", 32'(b_rv), 32'd0);

      for (int i = 0; i < 14; i++) run_vec(vecs[i]);

      // back-to-back accepts return back-to-back, in order
      tick();
      a_req = 1'b1; a_op = 6'd2; a_ops[0] = 32'd6; a_ops[1] = 32'd7;
      #1 chk("b2b gnt0", 32'(a_gnt), 32'd1);
      tick();
      a_op = 6'd1; a_ops[0] = 32'd10; a_ops[1] = 32'd3;
      #1 chk("b2b gnt1", 32'(a_gnt), 32'd1);
      tick();
      #1 chk("b2b full", 32'(a_gnt), 32'd0);
      a_req = 1'b0;
      chk("b2b rv0", 32'(a_rv), 32'd1);
      chk("b2b res0", a_res, 32'd42);
      tick();
      #1 chk("b2b rv1", 32'(a_rv), 32'd1);
      chk("b2b res1", a_res, 32'd7);
      tick();
      #1 chk("b2b idle", 32'(a_rv), 32'd0);

      // grant stall with req held and operands changing
      for (int i = 0; i < 3; i++) begin
         tick();
         a_req = 1'b1; a_stall = 1'b1; a_op = 6'd0;
         a_ops[0] = 32'(i * 11); a_ops[1] = 32'd1;
         #1 chk("stall gnt", 32'(a_gnt), 32'd0);
         chk("stall rv", 32'(a_rv), 32'd0);
      end
      tick();
      a_stall = 1'b0; a_ops[0] = 32'd40; a_ops[1] = 32'd2;
      #1 chk("stall release gnt", 32'(a_gnt), 32'd1);
      tick();
      a_req = 1'b0;
      #1 chk("stall early", 32'(a_rv), 32'd0);
      tick();
      #1 chk("stall rv", 32'(a_rv), 32'd1);
      chk("stall res", a_res, 32'd42);

      // occupancy: LATENCY=4, MAX_OUTSTANDING=2, req held high
      begin
         logic [10:0] exp_g, exp_v;
         logic [31:0] exp_r [11];
         exp_g = 11'b100_0110_0011;
         exp_v = 11'b110_0011_0000;
         foreach (exp_r[k]) exp_r[k] = 32'd0;
         exp_r[4] = 32'd100; exp_r[5] = 32'd101; exp_r[9] = 32'd105; exp_r[10] = 32'd106;
         for (int cyc = 0; cyc < 11; cyc++) begin
            tick();
            b_req = 1'b1; b_op = 6'd0; b_ops[0] = 32'(cyc); b_ops[1] = 32'd100;
            #1 chk($sformatf("occ gnt c%0d", cyc), 32'(b_gnt), 32'(exp_g[cyc]));
            chk($sformatf("occ rv c%0d", cyc), 32'(b_rv), 32'(exp_v[cyc]));
            chk($sformatf("occ res c%0d", cyc), b_res, exp_r[cyc]);
         end
         tick();
         b_req = 1'b0;
         for (int k = 0; k < 6; k++) tick();
      end

      // reset two cycles after two accepts drops them
      tick();
      b_req = 1'b1; b_ops[0] = 32'd1; b_ops[1] = 32'd1;
      #1 chk("rd gnt0", 32'(b_gnt), 32'd1);
      tick();
      b_ops[0] = 32'd2;
      #1 chk("rd gnt1", 32'(b_gnt), 32'd1);
      tick();
      rst_n = 1'b0;
      #1 chk("rd gnt in rst", 32'(b_gnt), 32'd0);
      tick();
      rst_n = 1'b1; b_req = 1'b0;
      begin
         int seen = 0;
         for (int k = 0; k < 8; k++) begin
            #1 if (b_rv) seen++;
            tick();
         end
         chk("rd dropped", 32'(seen), 32'd0);
      end
      b_req = 1'b1; b_ops[0] = 32'd9; b_ops[1] = 32'd9;
      #1 chk("rd post gnt0", 32'(b_gnt), 32'd1);
      tick();
      b_ops[0] = 32'd3; b_ops[1] = 32'd3;
      #1 chk("rd post gnt1", 32'(b_gnt), 32'd1);
      tick();
      #1 chk("rd post full", 32'(b_gnt), 32'd0);
      b_req = 1'b0;
      tick();
      #1 chk("rd post early", 32'(b_rv), 32'd0);
      tick();
      #1 chk("rd post rv0", 32'(b_rv), 32'd1);
      chk("rd post res0", b_res, 32'd18);
      tick();
      #1 chk("rd post rv1", 32'(b_rv), 32'd1);
      chk("rd post res1", b_res, 32'd6);
      tick();
      #1 chk("rd post idle", 32'(b_rv), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
